// File: rtl/pll_lock_reset.sv
// pll_lock_reset: PLL lock-driven reset sequencer for the fabric clock domain.
// Synchronizes the asynchronous PLL `locked` input, holds the system reset
// until lock has been stable for HOLD_CYCLES, and re-asserts it on loss of
// lock. Loss events from RUN are counted (saturating) and flagged (sticky).
// Optional macro PLL_LOCK_FILTER_EN: when defined, a loss in RUN requires
// FILTER_CYCLES consecutive low synchronized samples; otherwise a single low
// sample in RUN is a loss.
module pll_lock_reset #(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 1024,
  parameter int HOLD_W        = 11,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       clear_stats,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   loss;

  // Reject parameter sets outside the legal ranges at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 ||
      FILTER_CYCLES < 1 || (1 << HOLD_W) <= HOLD_CYCLES) begin : g_bad_params
    $error("pll_lock_reset: illegal parameter combination");
  end

  // Synchronizer chain for the asynchronous lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_LOCK_FILTER_EN
  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

  logic [FILT_W-1:0] filt_q, filt_d;

  // Count consecutive low samples in RUN; a run of FILTER_CYCLES is a loss.
  always_comb begin
    filt_d = '0;
    loss   = 1'b0;
    if (state_q == RUN && !lk_s) begin
      if (filt_q == FILT_W'(FILTER_CYCLES - 1)) begin
        loss = 1'b1;
      end else begin
        filt_d = filt_q + 1'b1;
      end
    end
  end

  // Filter counter register; clears on any high sample or when leaving RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  // Unfiltered: any low synchronized sample in RUN is a loss.
  assign loss = (state_q == RUN) && !lk_s;
`endif

  // Next-state and hold-counter logic.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (loss) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // State register; reset outputs are registered from the next state so they
  // change on the same edge as the transition while coming straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      hold_q      <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sys_reset_n <= (state_d == RUN);
      ready       <= (state_d == RUN);
    end
  end

  // Loss statistics; a loss on the same edge as clear_stats takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else if (loss) begin
      lock_lost <= 1'b1;
      if (clear_stats) begin
        loss_count <= 8'd1;
      end else if (loss_count != '1) begin
        loss_count <= loss_count + 8'd1;
      end
    end else if (clear_stats) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end
  end

endmodule

// File: tb/tb_pll_lock_reset.sv
// tb_pll_lock_reset: directed bench for pll_lock_reset with a streak-based
// reference model checked every cycle, plus literal timing expectations.
module tb_pll_lock_reset;

  localparam int S = 2;
  localparam int H = 16;
  localparam int F = 4;
`ifdef PLL_LOCK_FILTER_EN
  localparam int FE = F;
`else
  localparam int FE = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked = 1'b0;
  logic       clear_stats = 1'b0;
  logic       sys_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;

  int tests = 0;
  int fails = 0;

  pll_lock_reset #(
    .SYNC_STAGES  (S),
    .HOLD_CYCLES  (H),
    .HOLD_W       (5),
    .FILTER_CYCLES(F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .locked     (locked),
    .clear_stats(clear_stats),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: lock seen by the sequencer is `locked` delayed S edges.
  // Release needs H+1 consecutive high samples; loss needs FE consecutive lows.
  bit q_lk[$];
  bit lk;
  int ones, zeros, m_cnt;
  bit m_rdy, m_lost, m_loss, m_valid;

  always @(posedge clk) begin
    if (!reset_n) begin
      q_lk = {};
      for (int i = 0; i < S; i++) q_lk.push_back(1'b0);
      ones = 0; zeros = 0; m_cnt = 0;
      m_rdy = 1'b0; m_lost = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      lk = q_lk.pop_front();
      q_lk.push_back(locked);
      if (lk) begin ones++; zeros = 0; end
      else begin zeros++; ones = 0; end
      m_loss = 1'b0;
      if (m_rdy) begin
        if (zeros >= FE) begin m_rdy = 1'b0; m_loss = 1'b1; end
      end else if (ones >= H + 1) begin
        m_rdy = 1'b1;
      end
      if (m_loss) begin
        m_lost = 1'b1;
        m_cnt  = clear_stats ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (clear_stats) begin
        m_lost = 1'b0;
        m_cnt  = 0;
      end
    end
    if (m_valid) begin
      #1;
      check("model_sys_reset_n", sys_reset_n, m_rdy);
      check("model_ready", ready, m_rdy);
      check("model_lock_lost", lock_lost, m_lost);
      check("model_loss_count", loss_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    while (ready !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) check("wait_ready_timeout", ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up
    reset_n = 1'b0; locked = 1'b1; clear_stats = 1'b0;
    repeat (5) tick();
    check("rst_sys_reset_n", sys_reset_n, 0);
    check("rst_ready", ready, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_loss_count", loss_count, 0);
    reset_n = 1'b1;
    tick();                       // E0
    repeat (17) tick();           // E0+17
    check("pwrup_pre_release", sys_reset_n, 0);
    check("pwrup_pre_ready", ready, 0);
    tick();                       // E0+18
    check("pwrup_release", sys_reset_n, 1);
    check("pwrup_ready", ready, 1);
    check("pwrup_loss_count", loss_count, 0);

    // False start: abort HOLD at count 10
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();                       // E0
    repeat (12) tick();           // E0+12, hold count 10
    locked = 1'b0;
    repeat (3) tick();            // lows captured E0+13..E0+15
    locked = 1'b1;
    tick();                       // E0+16 = E1
    tick(); tick();               // E0+18
    check("fs_no_early_release", sys_reset_n, 0);
    repeat (15) tick();           // E1+17
    check("fs_pre_release", sys_reset_n, 0);
    tick();                       // E1+18
    check("fs_release", sys_reset_n, 1);
    check("fs_lock_lost", lock_lost, 0);
    check("fs_loss_count", loss_count, 0);

`ifdef PLL_LOCK_FILTER_EN
    // Short low pulse is filtered out
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (6) tick();
    check("filt_short_sys_reset_n", sys_reset_n, 1);
    check("filt_short_loss_count", loss_count, 0);
    check("filt_short_lock_lost", lock_lost, 0);
    // Four-cycle low pulse is a loss at E0+5
    locked = 1'b0;
    tick();                       // E0
    repeat (3) tick();            // E0+3
    locked = 1'b1;
    tick();                       // E0+4
    check("filt_loss_pre", sys_reset_n, 1);
    tick();                       // E0+5
    check("filt_loss_sys_reset_n", sys_reset_n, 0);
    check("filt_loss_ready", ready, 0);
    check("filt_loss_count", loss_count, 1);
    check("filt_loss_lock_lost", lock_lost, 1);
    repeat (16) tick();           // E0+21
    check("filt_rerelease_pre", sys_reset_n, 0);
    tick();                       // E0+22
    check("filt_rerelease", sys_reset_n, 1);
`else
    // Single-cycle low pulse in RUN is a loss at E0+2
    locked = 1'b0;
    tick();                       // E0
    locked = 1'b1;
    tick();                       // E0+1
    check("loss_pre", sys_reset_n, 1);
    tick();                       // E0+2
    check("loss_sys_reset_n", sys_reset_n, 0);
    check("loss_ready", ready, 0);
    check("loss_count", loss_count, 1);
    check("loss_lock_lost", lock_lost, 1);
    repeat (16) tick();           // E0+18
    check("rerelease_pre", sys_reset_n, 0);
    tick();                       // E0+19
    check("rerelease", sys_reset_n, 1);
`endif

    // Saturation: 260 further losses
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      repeat (FE) tick();
      locked = 1'b1;
      repeat (S) tick();
      wait_ready(60);
    end
    check("sat_loss_count", loss_count, 255);
    check("sat_lock_lost", lock_lost, 1);

    // Clear in RUN
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clear_loss_count", loss_count, 0);
    check("clear_lock_lost", lock_lost, 0);
    check("clear_ready_kept", ready, 1);

    // Clear coinciding with a loss: loss wins
    locked = 1'b0;
    repeat (FE) tick();
    locked = 1'b1;
    repeat (S - 1) tick();
    clear_stats = 1'b1;
    tick();                       // loss edge
    clear_stats = 1'b0;
    check("clr_loss_count", loss_count, 1);
    check("clr_loss_lock_lost", lock_lost, 1);
    check("clr_loss_sys_reset_n", sys_reset_n, 0);

    // Async reset mid-RUN
    wait_ready(60);
    check("async_pre_ready", ready, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_sys_reset_n", sys_reset_n, 0);
    check("async_ready", ready, 0);
    check("async_lock_lost", lock_lost, 0);
    check("async_loss_count", loss_count, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
